// File: rtl/dac_frame_scheduler_pkg.sv
// Shared types and constants for the DAC frame scheduler (package dac_sched_pkg).
// Frame geometry and counter widths live here so the top and the bench agree.
package dac_sched_pkg;

    localparam int DAC_FRAME_BITS = 16;
    localparam int CNT_SCK_W      = 5;
    localparam int FRAME_CNT_W    = 16;
    localparam int MIN_GAP_CYC    = 14;

    localparam logic [CNT_SCK_W-1:0] CNT_SCK_LAST = 5'd16;
    localparam logic [CNT_SCK_W-1:0] CNT_SCK_PRE  = 5'd15;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        HOLD  = 2'd3
    } state_e;

endpackage

// File: rtl/dac_frame_scheduler_rr_arbiter.sv
// Round-robin one-hot picker for the DAC frame scheduler.
// The pointer advances past the winner only when the pick is actually granted.
module rr_arbiter
    import dac_sched_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               grant_en,
    output logic [NUM_REQ-1:0] pick
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_REQ - 1);

    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;
    logic [PTR_W-1:0] idx_s;
    logic [PTR_W-1:0] pick_idx_s;
    logic             found_s;

    // First set request at or after the pointer, wrapping around.
    always_comb begin
        pick       = '0;
        found_s    = 1'b0;
        idx_s      = '0;
        pick_idx_s = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            idx_s = PTR_W'((int'(ptr_q) + off) % NUM_REQ);
            if (!found_s && req[idx_s]) begin
                found_s       = 1'b1;
                pick[idx_s]   = 1'b1;
                pick_idx_s    = idx_s;
            end else begin
                found_s = found_s;
            end
        end
        if (grant_en && found_s) begin
            ptr_d = (pick_idx_s == PTR_LAST) ? '0 : pick_idx_s + 1'b1;
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Pointer register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/dac_frame_scheduler.sv
// Arbitrates requesters onto one 16-bit serial DAC channel and generates cs/sck framing.
// Build option: DAC_SCHED_STATS_EN enables the completed-frame counter on frame_cnt.
module dac_frame_scheduler
    import dac_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int SCK_DIV = 4,
    parameter int GAP_CYC = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        key_state,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ*16-1:0]       req_data,
    output logic [NUM_REQ-1:0]          gnt,
    output logic                        done,
    output logic                        busy,
    output logic                        cs,
    output logic                        sck,
    output logic [CNT_SCK_W-1:0]        cnt_sck,
    output logic [DAC_FRAME_BITS-1:0]   data_sdi,
    output logic                        en_dac,
    output logic [FRAME_CNT_W-1:0]      frame_cnt
);

    localparam int TMR_MAX = (GAP_CYC > SCK_DIV) ? GAP_CYC : SCK_DIV;
    localparam int TMR_W   = $clog2(TMR_MAX);
    localparam logic [TMR_W-1:0] SCK_LAST = TMR_W'(SCK_DIV - 1);
    localparam logic [TMR_W-1:0] GAP_LAST = TMR_W'(GAP_CYC - 1);

    state_e                     state_q, state_d;
    logic [TMR_W-1:0]           timer_q, timer_d;
    logic                       sck_q, sck_d;
    logic                       cs_q, cs_d;
    logic [CNT_SCK_W-1:0]       cnt_q, cnt_d;
    logic [DAC_FRAME_BITS-1:0]  data_q, data_d;
    logic [NUM_REQ-1:0]         gnt_q, gnt_d;
    logic                       en_q, en_d;
    logic                       done_q, done_d;
    logic                       busy_q, busy_d;

    logic [NUM_REQ-1:0]         pick_s;
    logic [DAC_FRAME_BITS-1:0]  word_s;
    logic                       grant_s;

    assign grant_s = (state_q == IDLE) && key_state && (|req);

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .grant_en (grant_s),
        .pick     (pick_s)
    );

    // Winner's word, selected by the one-hot pick.
    always_comb begin
        word_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            word_s = word_s | (req_data[i*DAC_FRAME_BITS +: DAC_FRAME_BITS] & {DAC_FRAME_BITS{pick_s[i]}});
        end
    end

    // Next-state and framing outputs; key_state low aborts to IDLE from anywhere.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        sck_d   = sck_q;
        cs_d    = cs_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        gnt_d   = '0;
        en_d    = 1'b0;
        done_d  = 1'b0;
        if (!key_state) begin
            state_d = IDLE;
            timer_d = '0;
            sck_d   = 1'b0;
            cs_d    = 1'b1;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    timer_d = '0;
                    sck_d   = 1'b0;
                    cnt_d   = '0;
                    if (grant_s) begin
                        state_d = LOAD;
                        cs_d    = 1'b0;
                        data_d  = word_s;
                        gnt_d   = pick_s;
                        en_d    = 1'b1;
                    end else begin
                        state_d = IDLE;
                        cs_d    = 1'b1;
                    end
                end
                LOAD: begin
                    if (timer_q == SCK_LAST) begin
                        state_d = SHIFT;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                SHIFT: begin
                    if (timer_q == SCK_LAST) begin
                        timer_d = '0;
                        sck_d   = ~sck_q;
                        if (sck_q) begin
                            // Falling edge: advance the bit index; the 16th ends the frame.
                            cnt_d = cnt_q + 1'b1;
                            if (cnt_q == CNT_SCK_PRE) begin
                                cs_d    = 1'b1;
                                state_d = HOLD;
                            end else begin
                                state_d = SHIFT;
                            end
                        end else begin
                            cnt_d = cnt_q;
                        end
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                HOLD: begin
                    if (timer_q == GAP_LAST) begin
                        state_d = IDLE;
                        timer_d = '0;
                        cnt_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    timer_d = '0;
                    sck_d   = 1'b0;
                    cs_d    = 1'b1;
                    cnt_d   = '0;
                end
            endcase
        end
        busy_d = (state_d != IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            timer_q <= '0;
            sck_q   <= 1'b0;
            cs_q    <= 1'b1;
            cnt_q   <= '0;
            data_q  <= '0;
            gnt_q   <= '0;
            en_q    <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            sck_q   <= sck_d;
            cs_q    <= cs_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            gnt_q   <= gnt_d;
            en_q    <= en_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign gnt      = gnt_q;
    assign done     = done_q;
    assign busy     = busy_q;
    assign cs       = cs_q;
    assign sck      = sck_q;
    assign cnt_sck  = cnt_q;
    assign data_sdi = data_q;
    assign en_dac   = en_q;

`ifdef DAC_SCHED_STATS_EN
    logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;

    // Completed-frame counter, wraps naturally at 16 bits.
    always_comb begin
        if (done_d) begin
            frame_cnt_d = frame_cnt_q + 1'b1;
        end else begin
            frame_cnt_d = frame_cnt_q;
        end
    end

    // Frame counter register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_cnt_q <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign frame_cnt = frame_cnt_q;
`else
    assign frame_cnt = '0;
`endif

endmodule

// File: tb/tb_dac_frame_scheduler.sv
// Self-checking bench for dac_frame_scheduler (defaults NUM_REQ=4, SCK_DIV=4, GAP_CYC=16).
module tb_dac_frame_scheduler;

    localparam logic [15:0] W0 = 16'h1234;
    localparam logic [15:0] W1 = 16'hA5C3;
    localparam logic [15:0] W2 = 16'h5A0F;
    localparam logic [15:0] W3 = 16'hC3A5;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        key_state;
    logic [3:0]  req;
    logic [63:0] req_data;
    logic [3:0]  gnt;
    logic        done;
    logic        busy;
    logic        cs;
    logic        sck;
    logic [4:0]  cnt_sck;
    logic [15:0] data_sdi;
    logic        en_dac;
    logic [15:0] frame_cnt;

    int checks   = 0;
    int failures = 0;
    int exp_frames = 0;

    typedef struct {
        logic [3:0]  req;
        logic [3:0]  gnt;
        logic [15:0] data;
    } vec_t;

    vec_t tbl [12];

    dac_frame_scheduler #(
        .NUM_REQ (4),
        .SCK_DIV (4),
        .GAP_CYC (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_state (key_state),
        .req       (req),
        .req_data  (req_data),
        .gnt       (gnt),
        .done      (done),
        .busy      (busy),
        .cs        (cs),
        .sck       (sck),
        .cnt_sck   (cnt_sck),
        .data_sdi  (data_sdi),
        .en_dac    (en_dac),
        .frame_cnt (frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] exp_fcnt();
`ifdef DAC_SCHED_STATS_EN
        return exp_frames[15:0];
`else
        return 16'd0;
`endif
    endfunction

    task automatic check_reset_values();
        check("rst_cs", {31'd0, cs}, 32'd1);
        check("rst_sck", {31'd0, sck}, 32'd0);
        check("rst_cnt_sck", {27'd0, cnt_sck}, 32'd0);
        check("rst_data_sdi", {16'd0, data_sdi}, 32'd0);
        check("rst_gnt", {28'd0, gnt}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_en_dac", {31'd0, en_dac}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_frame_cnt", {16'd0, frame_cnt}, 32'd0);
    endtask

    // Raise req, wait for the grant, check it; leaves the bench at the grant cycle.
    task automatic wait_grant(input logic [3:0] r, input logic [3:0] eg, input logic [15:0] ed);
        int  n;
        logic got;
        req = r;
        n   = 0;
        got = 1'b0;
        while (!got && n < 10) begin
            @(negedge clk);
            n++;
            if (gnt != 4'd0) got = 1'b1;
        end
        check("gnt_seen", {31'd0, got}, 32'd1);
        check("gnt", {28'd0, gnt}, {28'd0, eg});
        check("en_dac_at_gnt", {31'd0, en_dac}, 32'd1);
        check("data_sdi_at_gnt", {16'd0, data_sdi}, {16'd0, ed});
        check("busy_at_gnt", {31'd0, busy}, 32'd1);
        check("cs_at_gnt", {31'd0, cs}, 32'd0);
        req = 4'd0;
    endtask

    // One complete frame with timing checks from grant to done.
    task automatic run_frame(input logic [3:0] r, input logic [3:0] eg, input logic [15:0] ed);
        int   n, rises, cs_low, hold16, first_rise;
        logic prev_sck, got, data_ok, pulse_bad;
        wait_grant(r, eg, ed);
        cs_low     = (cs == 1'b0) ? 1 : 0;
        rises      = 0;
        hold16     = 0;
        first_rise = -1;
        prev_sck   = sck;
        got        = 1'b0;
        data_ok    = 1'b1;
        pulse_bad  = 1'b0;
        n          = 0;
        while (!got && n < 400) begin
            @(negedge clk);
            n++;
            if (en_dac || gnt != 4'd0) pulse_bad = 1'b1;
            if (data_sdi != ed) data_ok = 1'b0;
            if (done) begin
                got = 1'b1;
            end else begin
                if (!cs) cs_low++;
                if (sck && !prev_sck) begin
                    rises++;
                    if (first_rise < 0) first_rise = n;
                end
                if (cs && cnt_sck == 5'd16) hold16++;
                prev_sck = sck;
            end
        end
        exp_frames++;
        check("done_seen", {31'd0, got}, 32'd1);
        check("gnt_to_done_cycles", n, 32'd148);
        check("cs_low_cycles", cs_low, 32'd132);
        check("sck_rises", rises, 32'd16);
        check("first_rise_offset", first_rise, 32'd8);
        check("hold_cnt16_cycles", hold16, 32'd16);
        check("data_sdi_stable", {31'd0, data_ok}, 32'd1);
        check("single_gnt_en_pulse", {31'd0, pulse_bad}, 32'd0);
        check("cnt_sck_at_done", {27'd0, cnt_sck}, 32'd0);
        check("busy_at_done", {31'd0, busy}, 32'd0);
        check("cs_at_done", {31'd0, cs}, 32'd1);
        check("frame_cnt", {16'd0, frame_cnt}, {16'd0, exp_fcnt()});
        @(negedge clk);
        check("done_one_cycle", {31'd0, done}, 32'd0);
    endtask

    // Grant a frame, drop key_state once cnt_sck reaches 7, check the abort.
    task automatic abort_frame(input logic [3:0] r, input logic [3:0] eg, input logic [15:0] ed);
        int   n, dones, gnts;
        logic got;
        wait_grant(r, eg, ed);
        n   = 0;
        got = 1'b0;
        while (!got && n < 400) begin
            @(negedge clk);
            n++;
            if (cnt_sck == 5'd7) got = 1'b1;
        end
        check("abort_cnt7_seen", {31'd0, got}, 32'd1);
        key_state = 1'b0;
        @(negedge clk);
        check("abort_cs", {31'd0, cs}, 32'd1);
        check("abort_sck", {31'd0, sck}, 32'd0);
        check("abort_cnt_sck", {27'd0, cnt_sck}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        dones = 0;
        gnts  = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) dones++;
            if (gnt != 4'd0) gnts++;
        end
        check("abort_no_done", dones, 32'd0);
        check("abort_no_gnt", gnts, 32'd0);
        check("abort_frame_cnt", {16'd0, frame_cnt}, {16'd0, exp_fcnt()});
        key_state = 1'b1;
    endtask

    initial begin
        int   n;
        logic got;

        tbl[0]  = '{4'b1111, 4'b0001, W0};
        tbl[1]  = '{4'b1111, 4'b0010, W1};
        tbl[2]  = '{4'b1111, 4'b0100, W2};
        tbl[3]  = '{4'b1111, 4'b1000, W3};
        tbl[4]  = '{4'b1111, 4'b0001, W0};
        tbl[5]  = '{4'b0010, 4'b0010, W1};
        tbl[6]  = '{4'b1100, 4'b0100, W2};
        tbl[7]  = '{4'b1000, 4'b1000, W3};
        tbl[8]  = '{4'b1001, 4'b0001, W0};
        tbl[9]  = '{4'b1001, 4'b1000, W3};
        tbl[10] = '{4'b0110, 4'b0010, W1};
        tbl[11] = '{4'b0011, 4'b0001, W0};

        rst_n     = 1'b0;
        key_state = 1'b1;
        req       = 4'd0;
        req_data  = {W3, W2, W1, W0};
        repeat (3) @(negedge clk);
        check_reset_values();
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 12; i++) begin
            run_frame(tbl[i].req, tbl[i].gnt, tbl[i].data);
        end

        // Abort mid-shift, then the same requester re-requests.
        abort_frame(4'b0010, 4'b0010, W1);
        run_frame(4'b0010, 4'b0010, W1);

        // Reset pulse during HOLD after a grant that moved the pointer to 3.
        wait_grant(4'b0100, 4'b0100, W2);
        n   = 0;
        got = 1'b0;
        while (!got && n < 400) begin
            @(negedge clk);
            n++;
            if (cs && cnt_sck == 5'd16) got = 1'b1;
        end
        check("hold_reached", {31'd0, got}, 32'd1);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_frames = 0;
        check_reset_values();
        @(negedge clk);

        // Pointer restarts at requester 0; three frames then one abort.
        run_frame(4'b1111, 4'b0001, W0);
        run_frame(4'b1111, 4'b0010, W1);
        run_frame(4'b1111, 4'b0100, W2);
        abort_frame(4'b1000, 4'b1000, W3);
        check("frame_cnt_after_abort", {16'd0, frame_cnt}, {16'd0, exp_fcnt()});
        run_frame(4'b1000, 4'b1000, W3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dac_frame_scheduler.md
Name: dac_frame_scheduler

Overview:
- Arbitrates up to NUM_REQ training-datapath requesters for a single 16-bit serial DAC channel.
- Round-robin arbitration; latches the winner's word.
- Generates the cs / sck / cnt_sck / data_sdi / en_dac framing that the DAC serializer consumes.
- Holds the bus idle long enough after each frame for the serializer's ldac sequence to finish.

Parameters:
- NUM_REQ, 4: number of requesters (2..8).
- SCK_DIV, 4: clk cycles per sck half-period (>=2).
- GAP_CYC, 16: cycles cs stays high with cnt_sck=16 after the last bit (>=14, covers ldac setup and pulse).

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- key_state  in  1  system run enable; low forces idle
- req  in  NUM_REQ  level request per requester; held until gnt
- req_data  in  NUM_REQ*16  word per requester; requester i at bits [16i+15:16i]
- gnt  out  NUM_REQ  one-hot, one-cycle grant pulse
- done  out  1  one-cycle pulse at frame completion
- busy  out  1  high in any state except IDLE
- cs  out  1  DAC chip select, active low
- sck  out  1  serial clock
- cnt_sck  out  5  bit index, 0..16
- data_sdi  out  16  latched frame word
- en_dac  out  1  one-cycle frame-start strobe
- frame_cnt  out  16  completed-frame count (optional feature)

Behaviour:
- Reset (rst_n low at a clk edge):
  - State: IDLE.
  - Outputs: cs=1, sck=0, cnt_sck=0, data_sdi=0, gnt=0, done=0, en_dac=0, busy=0, frame_cnt=0.
  - RR pointer points at requester 0.
- States: IDLE -> LOAD -> SHIFT -> HOLD -> IDLE.
- IDLE:
  - cs=1, sck=0, cnt_sck=0.
  - If key_state=1 and |req=1: pick the first set req at or after the pointer, wrapping around.
  - Next cycle: data_sdi<=winner word, gnt[winner]=1, en_dac=1, pointer<=winner+1 mod NUM_REQ, go LOAD.
- LOAD:
  - cs=0, sck=0, cnt_sck=0 for SCK_DIV cycles (sdi setup), then go SHIFT.
- SHIFT:
  - A divider toggles sck every SCK_DIV cycles, starting with a rising edge.
  - cnt_sck increments on each sck falling edge.
  - The falling edge that brings cnt_sck to 16 also sets cs=1 and moves to HOLD.
  - A frame is 16 full sck periods, i.e. 32*SCK_DIV cycles in SHIFT.
- HOLD:
  - cs=1, sck=0, cnt_sck held at 16 for GAP_CYC cycles.
  - Then cnt_sck=0, done=1 for one cycle, go IDLE.
- data_sdi is stable from LOAD through HOLD. It changes only at grant.
- Latency: req high in IDLE -> gnt/en_dac 1 cycle later -> first sck rise SCK_DIV+SCK_DIV cycles after LOAD entry.
- Throughput:
  - One frame per 1 + SCK_DIV + 32*SCK_DIV + GAP_CYC cycles.
  - The next arbitration happens in the cycle after done.
- Simultaneous requests: round-robin guarantees each active requester a grant within NUM_REQ frames.
- req changes outside IDLE are ignored.
- key_state low in any state:
  - Next cycle enters IDLE with cs=1, sck=0, cnt_sck=0.
  - No done is issued, frame_cnt is unchanged, and the pointer keeps its post-grant value.
  - The aborted requester must re-request.
- rst_n low mid-frame: identical to reset; it overrides key_state.
- frame_cnt wraps from 0xFFFF to 0.

Optional Feature:
- Macro DAC_SCHED_STATS_EN.
- Defined: frame_cnt increments on each done pulse.
- Undefined: frame_cnt is tied to 0, the port remains, and no counter logic is built.

Decomposition:
- Package dac_sched_pkg:
  - state enum (IDLE, LOAD, SHIFT, HOLD)
  - DAC_FRAME_BITS=16
  - CNT_SCK_LAST=5'd16
  - MIN_GAP_CYC=14
  - widths for cnt_sck and frame_cnt
- Sub-module rr_arbiter (NUM_REQ): combinational one-hot pick from req and pointer, plus the registered pointer update on grant.

Test Plan:
- Single request: req=4'b0010, req_data[31:16]=16'hA5C3, SCK_DIV=4, GAP_CYC=16 -> gnt=0010 and en_dac pulse one cycle later; data_sdi=A5C3; cs low for 4+128 cycles; exactly 16 sck rises; cnt_sck 0..16; done at HOLD exit; busy low afterwards.
- Round-robin fairness: req=4'b1111 held, re-asserted after each gnt -> grant order 0,1,2,3,0 with one done per grant.
- Pointer wrap: last grant=3, then req=4'b1001 -> gnt=0001; next frame -> gnt=1000.
- key_state dropped at cnt_sck=7 -> next cycle cs=1, sck=0, cnt_sck=0, busy=0; no done; frame_cnt unchanged; the request re-issued later is granted normally.
- Reset mid-HOLD (rst_n low one cycle) -> all outputs at reset values; the following request is granted from requester 0 priority.
- With DAC_SCHED_STATS_EN: 3 completed frames + 1 aborted frame -> frame_cnt=3. Without the macro: frame_cnt stays 0.
